// File: rtl/fetch_decode_buffer_if.sv
// Handshake and decode bus between the fetch stage, the fetch/decode buffer and the decode stage.
// The master modport is the environment (fetch and decode stages), and the slave modport is the buffer.
interface fetch_decode_buffer_if #(
    parameter int WIDTH = 32,
    parameter int PC_W  = 5,
    parameter int DEPTH = 2
);
    logic                       in_valid;
    logic                       in_ready;
    logic [WIDTH-1:0]           in_instr;
    logic [PC_W-1:0]            in_pc;
    logic                       flush;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTH-1:0]           out_instr;
    logic [PC_W-1:0]            out_pc_plus4;
    logic [5:0]                 opcode;
    logic [4:0]                 rs;
    logic [4:0]                 rt;
    logic [4:0]                 rd;
    logic [4:0]                 shamt;
    logic [5:0]                 funct;
    logic [31:0]                imm_sext;
    logic [25:0]                jaddr;
    logic                       is_rtype;
    logic                       is_jtype;
    logic                       is_itype;
    logic [$clog2(DEPTH+1)-1:0] count;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_instr, out_pc_plus4, opcode, rs, rt, rd,
               shamt, funct, imm_sext, jaddr, is_rtype, is_jtype, is_itype, count
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_instr, out_pc_plus4, opcode, rs, rt, rd,
               shamt, funct, imm_sext, jaddr, is_rtype, is_jtype, is_itype, count
    );
endinterface

// File: rtl/fetch_decode_buffer.sv
// Small FIFO between fetch and decode that holds {instr, pc+4} pairs.
// It presents the head entry with the MIPS fields already split and the instruction format classified.
module fetch_decode_buffer #(
    parameter int WIDTH = 32,
    parameter int PC_W  = 5,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_decode_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] instrMem [DEPTH];
    logic [PC_W-1:0]  pcMem    [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] cnt;
    logic             full;
    logic             notEmpty;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;

    assign full     = (cnt == CNT_W'(DEPTH));
    assign notEmpty = (cnt != '0);
    assign push     = bus.in_valid && !full;
    assign pop      = notEmpty && bus.out_ready;

    // Storage is not reset; only the pointers and the count define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !reset && !bus.flush) begin
            instrMem[wrPtr] <= bus.in_instr;
            pcMem[wrPtr]    <= bus.in_pc + PC_W'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            if (push && !pop)      cnt <= cnt + CNT_W'(1);
            else if (pop && !push) cnt <= cnt - CNT_W'(1);
        end
    end

    // An empty buffer presents all zeros, so decode sees a NOP.
    assign head             = notEmpty ? instrMem[rdPtr] : '0;
    assign bus.out_pc_plus4 = notEmpty ? pcMem[rdPtr] : '0;
    assign bus.out_instr    = head;
    assign bus.out_valid    = notEmpty;
    assign bus.in_ready     = !full;
    assign bus.count        = cnt;

    assign bus.opcode   = head[31:26];
    assign bus.rs       = head[25:21];
    assign bus.rt       = head[20:16];
    assign bus.rd       = head[15:11];
    assign bus.shamt    = head[10:6];
    assign bus.funct    = head[5:0];
    assign bus.imm_sext = {{16{head[15]}}, head[15:0]};
    assign bus.jaddr    = head[25:0];

    assign bus.is_rtype = notEmpty && (head[31:26] == 6'd0);
    assign bus.is_jtype = notEmpty && ((head[31:26] == 6'd2) || (head[31:26] == 6'd3));
    assign bus.is_itype = notEmpty && !bus.is_rtype && !bus.is_jtype;
endmodule
